// File: rtl/portal_word_serializer_pkg.sv
// Shared portal definitions: message geometry, header field positions,
// serializer state encoding and the header length clamp.
package portal_word_serializer_pkg;

  localparam int PORTAL_MSG_WIDTH  = 128;
  localparam int PORTAL_WORD_WIDTH = 32;
  localparam int PORTAL_MAX_WORDS  = 4;

  // len must hold 1..MAX_WORDS, idx must hold 0..MAX_WORDS-1
  localparam int LEN_W = $clog2(PORTAL_MAX_WORDS + 1);
  localparam int IDX_W = $clog2(PORTAL_MAX_WORDS);

  // Header layout inside the low message word
  localparam int HDR_LEN_LSB    = 0;
  localparam int HDR_LEN_MSB    = 15;
  localparam int HDR_METHOD_LSB = 16;
  localparam int HDR_METHOD_MSB = 31;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  // A zero count still emits the header word; oversize counts are cut
  // down to what the buffer physically holds.
  function automatic logic [LEN_W-1:0] clamp_len(input logic [15:0] cnt);
    if (cnt == 16'd0)
      return LEN_W'(1);
    else if (cnt > 16'(PORTAL_MAX_WORDS))
      return LEN_W'(PORTAL_MAX_WORDS);
    else
      return cnt[LEN_W-1:0];
  endfunction

  function automatic logic len_is_bad(input logic [15:0] cnt);
    return (cnt == 16'd0) || (cnt > 16'(PORTAL_MAX_WORDS));
  endfunction

endpackage

// File: rtl/portal_msg_buffer.sv
// One message holding register: payload, clamped length and a valid flag.
// load has priority over clear.
module portal_msg_buffer
  import portal_word_serializer_pkg::*;
#(
  parameter int W  = PORTAL_MSG_WIDTH,
  parameter int LW = LEN_W
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic          clear,
  input  logic [W-1:0]  load_data,
  input  logic [LW-1:0] load_len,
  output logic [W-1:0]  data,
  output logic [LW-1:0] len,
  output logic          valid
);

  // Capture a message on load, drop validity on clear
  always_ff @(posedge clk) begin
    if (rst) begin
      data  <= '0;
      len   <= '0;
      valid <= 1'b0;
    end else if (load) begin
      data  <= load_data;
      len   <= load_len;
      valid <= 1'b1;
    end else if (clear) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/portal_word_serializer.sv
// Portal word serializer: takes one 128-bit portal message per handshake
// and emits it as a header-length-driven sequence of 32-bit words.
// Optional macro PORTAL_SERIALIZER_PREFETCH_EN adds a second holding
// buffer so the next message is accepted while the current one drains.
module portal_word_serializer
  import portal_word_serializer_pkg::*;
#(
  parameter int MSG_WIDTH  = PORTAL_MSG_WIDTH,
  parameter int WORD_WIDTH = PORTAL_WORD_WIDTH,
  parameter int MAX_WORDS  = PORTAL_MAX_WORDS
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  in_enq__ENA,
  input  logic [MSG_WIDTH-1:0]  in_enq_v,
  output logic                  in_enq__RDY,
  output logic                  out_enq__ENA,
  output logic [WORD_WIDTH-1:0] out_enq_v,
  output logic                  out_last,
  input  logic                  out_enq__RDY,
  output logic [31:0]           status_msgCount,
  output logic                  status_badLen
);

  state_t            state;
  logic [IDX_W-1:0]  idx;
  logic [31:0]       msg_count;
  logic              bad_len;

  logic [MSG_WIDTH-1:0] cur_data;
  logic [LEN_W-1:0]     cur_len;
  logic                 cur_valid;
  logic                 cur_load, cur_clear;
  logic [MSG_WIDTH-1:0] cur_load_data;
  logic [LEN_W-1:0]     cur_load_len;

  logic [MAX_WORDS-1:0][WORD_WIDTH-1:0] cur_words;

  logic [15:0]      hdr_cnt;
  logic [LEN_W-1:0] in_len;
  logic             accept, sending, last, last_xfer;

  assign hdr_cnt = in_enq_v[HDR_LEN_MSB:HDR_LEN_LSB];
  assign in_len  = clamp_len(hdr_cnt);
  assign accept  = in_enq__ENA && in_enq__RDY;

  assign cur_words = cur_data;
  assign sending   = (state == SEND) && cur_valid;
  assign last      = sending && (LEN_W'(idx) == cur_len - LEN_W'(1));
  assign last_xfer = out_enq__ENA && last;

  assign out_enq__ENA = sending && out_enq__RDY;
  assign out_enq_v    = sending ? cur_words[idx] : '0;
  assign out_last     = last;

  assign status_msgCount = msg_count;
  assign status_badLen   = bad_len;

`ifdef PORTAL_SERIALIZER_PREFETCH_EN
  logic [MSG_WIDTH-1:0] n_data;
  logic [LEN_W-1:0]     n_len;
  logic                 n_valid, n_load, n_clear;

  assign in_enq__RDY = !n_valid;
  // accept implies !n_valid, so a waiting message always wins the reload
  assign cur_load      = (accept && (state == IDLE || last_xfer)) || (last_xfer && n_valid);
  assign cur_load_data = n_valid ? n_data : in_enq_v;
  assign cur_load_len  = n_valid ? n_len  : in_len;
  assign n_load        = accept && (state == SEND) && !last_xfer;
  assign n_clear       = last_xfer && n_valid;

  portal_msg_buffer #(.W(MSG_WIDTH), .LW(LEN_W)) u_next_buf (
    .clk(CLK), .rst(RST), .load(n_load), .clear(n_clear),
    .load_data(in_enq_v), .load_len(in_len),
    .data(n_data), .len(n_len), .valid(n_valid)
  );
`else
  assign in_enq__RDY   = (state == IDLE);
  assign cur_load      = accept;
  assign cur_load_data = in_enq_v;
  assign cur_load_len  = in_len;
`endif

  assign cur_clear = last_xfer && !cur_load;

  portal_msg_buffer #(.W(MSG_WIDTH), .LW(LEN_W)) u_cur_buf (
    .clk(CLK), .rst(RST), .load(cur_load), .clear(cur_clear),
    .load_data(cur_load_data), .load_len(cur_load_len),
    .data(cur_data), .len(cur_len), .valid(cur_valid)
  );

  // Sequencer: word index, state, completed-message count, sticky bad length
  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= IDLE;
      idx       <= '0;
      msg_count <= '0;
      bad_len   <= 1'b0;
    end else begin
      if (accept && len_is_bad(hdr_cnt))
        bad_len <= 1'b1;
      case (state)
        IDLE: begin
          if (accept) begin
            state <= SEND;
            idx   <= '0;
          end
        end
        SEND: begin
          if (out_enq__ENA) begin
            if (last) begin
              msg_count <= msg_count + 32'd1;
              idx       <= '0;
              state     <= cur_load ? SEND : IDLE;
            end else begin
              idx <= idx + IDX_W'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_portal_word_serializer.sv
// Self-checking bench for portal_word_serializer. A queue of expected
// words, derived from each offered message's header count, is drained
// against the DUT output stream.
module tb_portal_word_serializer;

  logic         CLK = 1'b0;
  logic         RST = 1'b1;
  logic         in_ena = 1'b0;
  logic [127:0] in_v = '0;
  logic         in_rdy;
  logic         out_ena;
  logic [31:0]  out_v;
  logic         out_last;
  logic         out_rdy = 1'b0;
  logic [31:0]  msg_count;
  logic         bad_len;

  int   n_assert = 0;
  int   n_fail   = 0;
  int   exp_msgs = 0;
  logic exp_bad  = 1'b0;

  logic [31:0] q_word[$];
  logic        q_last[$];

  always #5 CLK = ~CLK;

  portal_word_serializer dut (
    .CLK(CLK), .RST(RST),
    .in_enq__ENA(in_ena), .in_enq_v(in_v), .in_enq__RDY(in_rdy),
    .out_enq__ENA(out_ena), .out_enq_v(out_v), .out_last(out_last),
    .out_enq__RDY(out_rdy),
    .status_msgCount(msg_count), .status_badLen(bad_len)
  );

  // Offering a message while the block is not ready is a protocol violation
  always @(posedge CLK) begin
    if (!RST)
      assert (!(in_ena && !in_rdy)) else begin
        n_fail++;
        $error("FAIL protocol: enq offered while in_rdy=0");
      end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: words emitted = header count, with 0 -> 1 and >4 -> 4
  task automatic push_model(input logic [127:0] v);
    int cnt, n;
    cnt = int'(v[15:0]);
    if (cnt == 0) begin
      n = 1; exp_bad = 1'b1;
    end else if (cnt > 4) begin
      n = 4; exp_bad = 1'b1;
    end else begin
      n = cnt;
    end
    for (int i = 0; i < n; i++) begin
      q_word.push_back(v[32*i +: 32]);
      q_last.push_back(i == n - 1);
    end
  endtask

  task automatic offer(input logic [127:0] v);
    int t;
    t = 0;
    while (!in_rdy && t < 50) begin
      @(posedge CLK); #1; t++;
    end
    chk("in_rdy_offer", 32'(in_rdy), 32'd1);
    if (in_rdy) begin
      in_ena = 1'b1; in_v = v; push_model(v);
      @(posedge CLK); #1;
      in_ena = 1'b0;
    end
  endtask

  // mode 0: consumer always ready, 1: random, 2: pattern 1,0,0,1,1,1...
  task automatic drain(input int mode);
    int k;
    k = 0;
    while (q_word.size() > 0 && k < 100) begin
      case (mode)
        0:       out_rdy = 1'b1;
        1:       out_rdy = ($urandom_range(3) != 0);
        default: out_rdy = !(k == 1 || k == 2);
      endcase
      @(negedge CLK);
      chk("word", out_v, q_word[0]);
      chk("last", 32'(out_last), 32'(q_last[0]));
      chk("ena", 32'(out_ena), 32'(out_rdy));
`ifdef PORTAL_SERIALIZER_PREFETCH_EN
      chk("in_rdy_send", 32'(in_rdy), 32'd1);
`else
      chk("in_rdy_send", 32'(in_rdy), 32'd0);
`endif
      if (out_rdy) begin
        if (q_last[0]) exp_msgs++;
        void'(q_word.pop_front());
        void'(q_last.pop_front());
      end
      @(posedge CLK); #1;
      k++;
    end
    chk("drain_timeout", 32'(q_word.size()), 32'd0);
    out_rdy = 1'b1;
    @(negedge CLK);
    chk("idle_ena", 32'(out_ena), 32'd0);
    chk("idle_in_rdy", 32'(in_rdy), 32'd1);
    chk("msg_count", msg_count, 32'(exp_msgs));
    chk("bad_len", 32'(bad_len), 32'(exp_bad));
    @(posedge CLK); #1;
    out_rdy = 1'b0;
  endtask

  initial begin
    logic [127:0] v;

    // Reset held two cycles
    @(posedge CLK); @(posedge CLK); #1;
    RST = 1'b0;
    @(negedge CLK);
    chk("rst_in_rdy", 32'(in_rdy), 32'd1);
    chk("rst_ena", 32'(out_ena), 32'd0);
    chk("rst_word", out_v, 32'd0);
    chk("rst_last", 32'(out_last), 32'd0);
    chk("rst_msg_count", msg_count, 32'd0);
    chk("rst_bad_len", 32'(bad_len), 32'd0);
    @(posedge CLK); #1;

    // Two-word message
    offer({64'd0, 32'h12345678, 16'd0, 16'd2});
    drain(0);

    // Four-word message with stalls
    offer({32'hDDDD_DDDD, 32'hCCCC_CCCC, 32'hBBBB_BBBB, 32'h0002_0004});
    drain(2);

    // Bad lengths
    offer({32'h4444_4444, 32'h3333_3333, 32'h2222_2222, 32'h0005_0000});
    drain(0);
    offer({32'h8888_8888, 32'h7777_7777, 32'h6666_6666, 32'h0006_0007});
    drain(1);

    // Random messages, counts 0..6, random back-pressure
    for (int m = 0; m < 20; m++) begin
      v[127:32] = {$urandom(), $urandom(), $urandom()};
      v[31:16]  = 16'($urandom());
      v[15:0]   = 16'($urandom_range(6));
      offer(v);
      drain(1);
    end

    // Reset in the middle of a four-word message
    offer({32'hD0D0_D0D0, 32'hC0C0_C0C0, 32'hB0B0_B0B0, 32'h0009_0004});
    out_rdy = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(negedge CLK);
      chk("mid_word", out_v, q_word[0]);
      void'(q_word.pop_front());
      void'(q_last.pop_front());
      @(posedge CLK); #1;
    end
    out_rdy = 1'b0;
    RST = 1'b1;
    @(posedge CLK); #1;
    RST = 1'b0;
    q_word.delete(); q_last.delete();
    exp_msgs = 0; exp_bad = 1'b0;
    out_rdy = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge CLK);
      chk("post_rst_ena", 32'(out_ena), 32'd0);
      chk("post_rst_in_rdy", 32'(in_rdy), 32'd1);
      chk("post_rst_msg_count", msg_count, 32'd0);
      @(posedge CLK); #1;
    end

`ifdef PORTAL_SERIALIZER_PREFETCH_EN
    // Two back-to-back two-word messages must stream with no gap
    in_ena = 1'b1;
    in_v = {64'd0, 32'hA1A1_A1A1, 32'h0011_0002};
    push_model(in_v);
    @(posedge CLK); #1;
    in_v = {64'd0, 32'hB1B1_B1B1, 32'h0022_0002};
    push_model(in_v);
    for (int k = 0; k < 4; k++) begin
      @(negedge CLK);
      if (k == 0) chk("pf_in_rdy", 32'(in_rdy), 32'd1);
      chk("pf_ena", 32'(out_ena), 32'd1);
      chk("pf_word", out_v, q_word[0]);
      chk("pf_last", 32'(out_last), 32'(q_last[0]));
      if (q_last[0]) exp_msgs++;
      void'(q_word.pop_front());
      void'(q_last.pop_front());
      @(posedge CLK); #1;
      in_ena = 1'b0;
    end
    @(negedge CLK);
    chk("pf_msg_count", msg_count, 32'd2);
    chk("pf_idle_ena", 32'(out_ena), 32'd0);
    @(posedge CLK); #1;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/portal_word_serializer.md
Name: portal_word_serializer

Overview:
- Downstream stage of the indication method-to-pipe marshaller.
- Accepts one 128-bit portal message per handshake and emits it as a sequence of 32-bit words toward the host bus/CSR FIFO.
- The message header occupies the low word:
  - v[15:0] = total word count, including the header.
  - v[31:16] = method number.
- The word sequence is variable-length, driven by that header count.

Parameters:
- MSG_WIDTH, 128, message width in bits; must equal WORD_WIDTH*MAX_WORDS.
- WORD_WIDTH, 32, output word width in bits.
- MAX_WORDS, 4, maximum words per message.

Ports:
- CLK  input  1  clock; all state changes on its rising edge.
- RST  input  1  reset, synchronous, active-high.
- in$enq__ENA  input  1  message transfer strobe; asserted only when in$enq__RDY=1.
- in$enq$v  input  128  message; header in [31:0].
- in$enq__RDY  output  1  block can accept a message this cycle.
- out$enq__ENA  output  1  word transfer this cycle.
- out$enq$v  output  32  current word.
- out$last  output  1  current word is the final word of its message.
- out$enq__RDY  input  1  consumer can take a word.
- status$msgCount  output  32  messages fully emitted, wrapping.
- status$badLen  output  1  sticky: a header count of 0 or >MAX_WORDS was received.

Behaviour:
- Reset (RST=1 at a clock edge, synchronous and active-high):
  - State = IDLE; buffers are invalid.
  - idx=0, len=0, msgCount=0, badLen=0.
  - Outputs: in$enq__RDY=1 after reset, out$enq__ENA=0, out$enq$v=0, out$last=0.
  - Reset asserted mid-message discards the partial message. No further words are emitted for it, and msgCount is not incremented.
- Registers: buf (128), len (3 bits), idx (2 bits), state {IDLE, SEND}.
- Length clamp, applied at acceptance:
  - len = 1 if count==0.
  - len = MAX_WORDS if count>MAX_WORDS.
  - len = count otherwise.
  - Either clamp sets badLen, which is cleared only by reset.
- IDLE:
  - in$enq__RDY=1.
  - On in$enq__ENA: buf<=v, len<=clamp, idx<=0, go to SEND.
- SEND:
  - out$enq__ENA = out$enq__RDY (combinational, in rule style).
  - out$enq$v = buf[idx*32 +: 32].
  - out$last = (idx==len-1).
  - On out$enq__ENA with out$last=0: idx<=idx+1.
  - On out$enq__ENA with out$last=1: msgCount<=msgCount+1, idx<=0, go to IDLE (or reload; see Optional Feature).
- When state is not SEND (or no buffer is valid): out$enq__ENA=0 and out$enq$v=0.
- Latency: a message accepted at edge N presents word 0 with ENA possible in cycle N+1. A message of L words takes at least L cycles to drain.
- Stall: while out$enq__RDY=0, out$enq$v/out$last are held stable and idx does not change.
- Without the optional feature, in$enq__RDY=0 throughout SEND. The gap between messages is therefore one cycle.
- msgCount wraps from 0xFFFFFFFF to 0 without affecting badLen.
- in$enq__ENA while in$enq__RDY=0 is a protocol violation. It is ignored, and the bench flags it with an assertion.

Optional Feature:
- Macro: PORTAL_SERIALIZER_PREFETCH_EN.
- When defined:
  - Adds a second 128-bit holding buffer (nbuf, nlen, nvalid).
  - in$enq__RDY = !nvalid, so a message is accepted during SEND.
  - On the last-word transfer with nvalid=1: buf/len are loaded from nbuf/nlen and nvalid is cleared, staying in SEND. Back-to-back messages stream with zero idle cycles.
  - If a new message is accepted in the same cycle as the last-word transfer with nvalid=0, it loads directly into buf and stays in SEND.
- When undefined: single-buffer behaviour as above.

Decomposition:
- Shared portal package:
  - Header field positions: LEN [15:0], METHOD [31:16].
  - MSG_WIDTH=128, WORD_WIDTH=32.
  - The state enum.
  - The clamp function for length.
- One natural sub-module, portal_msg_buffer: a 128-bit register with valid/len, instantiated once normally and twice with prefetch.

Test Plan:
- Reset then idle: RST high 2 cycles, release → in$enq__RDY=1, out$enq__ENA=0, msgCount=0, badLen=0.
- heard message: v={64'd0,32'h12345678,16'd0,16'd2}, out$enq__RDY=1 → words 0x00000002 then 0x12345678, out$last on 2nd only, msgCount=1.
- 4-word message with out$enq__RDY toggled 1,0,0,1,1,1:
  - Required: words 0x00020004, b, c, d emitted in order.
  - Required: word held stable during the two stall cycles.
  - Required: in$enq__RDY=0 until the last word (non-prefetch).
- Bad lengths:
  - Header count 0 → exactly 1 word emitted, badLen=1.
  - Header count 7 → exactly 4 words emitted, badLen stays 1.
- Mid-message reset: assert RST after word 1 of a 4-word message → no further ENA, msgCount unchanged, in$enq__RDY=1 after release.
- PORTAL_SERIALIZER_PREFETCH_EN defined, two 2-word messages offered continuously with out$enq__RDY=1 → 4 consecutive ENA cycles with no gap, msgCount=2.
